// File: rtl/lcb_rx_collector.sv
// Collects one fixed-length LCB UART response per channel and drains complete
// packets round-robin as a single tagged byte stream with valid/ready flow control.
module lcb_rx_collector #(
   parameter int NCH  = 5,
   parameter int DW   = 8,
   parameter int PKT  = 16,
   parameter int TOUT = 2000,
   parameter int CW   = (NCH > 1) ? $clog2(NCH) : 1,
   parameter int IW   = $clog2(PKT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    i_valid,
   input  logic [NCH*DW-1:0] i_data,
   input  logic              i_flush,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DW-1:0]     o_data,
   output logic [CW-1:0]     o_chan,
   output logic [IW-1:0]     o_idx,
   output logic              o_last,
   output logic              o_busy,
   output logic [NCH-1:0]    o_full,
   output logic [NCH-1:0]    o_ovf,
   output logic [NCH-1:0]    o_tout
);

   localparam int            TW       = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
   localparam logic [TW-1:0] TOUT_RL  = TW'(TOUT);
   localparam logic [IW-1:0] LAST_IDX = IW'(PKT - 1);
   localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);

   typedef enum logic [1:0] {F_EMPTY, F_FILLING, F_FULL} fill_st_e;
   typedef enum logic       {D_IDLE, D_SEND} drain_st_e;

   fill_st_e         fst_q  [NCH];
   fill_st_e         fst_d  [NCH];
   fill_st_e         st_eff [NCH];
   logic [IW-1:0]    wr_q   [NCH];
   logic [IW-1:0]    wr_d   [NCH];
   logic [IW-1:0]    wr_eff [NCH];
   logic [IW-1:0]    wa     [NCH];
   logic [TW-1:0]    tcnt_q [NCH];
   logic [TW-1:0]    tcnt_d [NCH];
   logic [NCH-1:0]   ovf_q, ovf_d;
   logic [NCH-1:0]   tout_q, tout_d;
   logic [NCH-1:0]   we;
   logic [NCH-1:0]   full_vec;
   logic [DW-1:0]    pkt_mem [NCH][PKT];

   drain_st_e        dst_q, dst_d;
   logic [CW-1:0]    chan_q, chan_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    ptr_q, ptr_d;
   logic             drain_done;
   logic             gnt_found;
   logic [CW-1:0]    gnt_chan;
   logic [2*NCH-1:0] dbl;
   logic [NCH-1:0]   rot;
   logic [CW:0]      sum;

   // Handshake: a beat transfers on a cycle where o_valid && i_ready; o_valid and the
   // beat fields hold until then, and o_valid only falls after the last beat transfers.
   assign drain_done = (dst_q == D_SEND) && i_ready && (idx_q == LAST_IDX);

   always_comb begin
      full_vec = '0;
      ovf_d    = '0;
      tout_d   = '0;
      we       = '0;
      for (int c = 0; c < NCH; c++) begin
         full_vec[c] = (fst_q[c] == F_FULL);
         tcnt_d[c]   = tcnt_q[c];
         wa[c]       = '0;
         ovf_d[c]    = ovf_q[c] & ~i_flush;
         tout_d[c]   = tout_q[c] & ~i_flush;
         // A flush abandons a partial packet before this cycle's byte is considered.
         st_eff[c]   = fst_q[c];
         wr_eff[c]   = wr_q[c];
         if (i_flush && (fst_q[c] == F_FILLING)) begin
            st_eff[c] = F_EMPTY;
            wr_eff[c] = '0;
         end
         fst_d[c] = st_eff[c];
         wr_d[c]  = wr_eff[c];
         if (st_eff[c] == F_FULL) begin
            if (i_valid[c]) ovf_d[c] = 1'b1;
            if (drain_done && (chan_q == CW'(c))) begin
               fst_d[c] = F_EMPTY;
               wr_d[c]  = '0;
            end
         end else if (i_valid[c]) begin
            we[c]     = 1'b1;
            wa[c]     = wr_eff[c];
            tcnt_d[c] = TOUT_RL;
            if (wr_eff[c] == LAST_IDX) begin
               fst_d[c] = F_FULL;
               wr_d[c]  = '0;
            end else begin
               fst_d[c] = F_FILLING;
               wr_d[c]  = wr_eff[c] + IW'(1);
            end
         end else if ((st_eff[c] == F_FILLING) && (TOUT > 0)) begin
            if (tcnt_q[c] <= TW'(1)) begin
               fst_d[c]  = F_EMPTY;
               wr_d[c]   = '0;
               tout_d[c] = 1'b1;
            end else begin
               tcnt_d[c] = tcnt_q[c] - TW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NCH; c++) begin
            fst_q[c]  <= F_EMPTY;
            wr_q[c]   <= '0;
            tcnt_q[c] <= '0;
         end
         ovf_q  <= '0;
         tout_q <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            fst_q[c]  <= fst_d[c];
            wr_q[c]   <= wr_d[c];
            tcnt_q[c] <= tcnt_d[c];
         end
         ovf_q  <= ovf_d;
         tout_q <= tout_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (we[c]) pkt_mem[c][wa[c]] <= i_data[c*DW +: DW];
      end
   end

   // Rotate the full map so bit 0 is the pointer; the lowest set bit is the grant.
   always_comb begin
      gnt_found = 1'b0;
      gnt_chan  = '0;
      sum       = '0;
      dbl       = {full_vec, full_vec} >> ptr_q;
      rot       = dbl[NCH-1:0];
      for (int i = NCH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum = {1'b0, ptr_q} + (CW+1)'(i);
            if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
            gnt_found = 1'b1;
            gnt_chan  = sum[CW-1:0];
         end
      end
   end

   always_comb begin
      dst_d  = dst_q;
      chan_d = chan_q;
      idx_d  = idx_q;
      ptr_d  = ptr_q;
      case (dst_q)
         D_IDLE: begin
            if (gnt_found) begin
               dst_d  = D_SEND;
               chan_d = gnt_chan;
               idx_d  = '0;
            end
         end
         D_SEND: begin
            if (i_ready) begin
               if (idx_q == LAST_IDX) begin
                  dst_d = D_IDLE;
                  idx_d = '0;
                  ptr_d = (chan_q == LAST_CH) ? '0 : chan_q + CW'(1);
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: dst_d = D_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dst_q  <= D_IDLE;
         chan_q <= '0;
         idx_q  <= '0;
         ptr_q  <= '0;
      end else begin
         dst_q  <= dst_d;
         chan_q <= chan_d;
         idx_q  <= idx_d;
         ptr_q  <= ptr_d;
      end
   end

   assign o_valid = (dst_q == D_SEND);
   assign o_busy  = o_valid;
   assign o_chan  = chan_q;
   assign o_idx   = idx_q;
   assign o_last  = o_valid && (idx_q == LAST_IDX);
   assign o_data  = o_valid ? pkt_mem[chan_q][idx_q] : '0;
   assign o_full  = full_vec;
   assign o_ovf   = ovf_q;
   assign o_tout  = tout_q;

endmodule

// File: tb/tb_lcb_rx_collector.sv
// Randomised bench for lcb_rx_collector: a per-cycle packet/silence model predicts
// the flags and the drained beat stream, which is scoreboarded beat by beat.
module tb_lcb_rx_collector;

   localparam int NCH  = 5;
   localparam int DW   = 8;
   localparam int PKT  = 16;
   localparam int TOUT = 50;
   localparam int CW   = 3;
   localparam int IW   = 4;
   localparam int W    = CW + IW + DW;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    i_valid;
   logic [NCH*DW-1:0] i_data;
   logic              i_flush;
   logic              i_ready;
   logic              o_valid;
   logic [DW-1:0]     o_data;
   logic [CW-1:0]     o_chan;
   logic [IW-1:0]     o_idx;
   logic              o_last;
   logic              o_busy;
   logic [NCH-1:0]    o_full;
   logic [NCH-1:0]    o_ovf;
   logic [NCH-1:0]    o_tout;

   lcb_rx_collector #(.NCH(NCH), .DW(DW), .PKT(PKT), .TOUT(TOUT), .CW(CW), .IW(IW)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_flush(i_flush),
      .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data), .o_chan(o_chan),
      .o_idx(o_idx), .o_last(o_last), .o_busy(o_busy), .o_full(o_full),
      .o_ovf(o_ovf), .o_tout(o_tout)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int n_cmp = 0;
   int n_err = 0;
   int rdy_mode = 0;
   int pat_cnt = 0;

   // scoreboard and reference model
   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] m_part [NCH][PKT];
   logic [DW-1:0] m_pkt  [NCH][PKT];
   int            m_cnt  [NCH];
   int            m_sil  [NCH];
   bit            m_full [NCH];
   bit            m_ovf  [NCH];
   bit            m_tout [NCH];
   int            m_busy, m_chan, m_idx, m_ptr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = 0; m_sil[c] = 0; m_full[c] = 0; m_ovf[c] = 0; m_tout[c] = 0;
      end
      m_busy = 0; m_chan = 0; m_idx = 0; m_ptr = 0;
      exp_q.delete();
   endtask

   // One clock edge of the reference behaviour, driven by the current bench inputs.
   task automatic model_step();
      int  start;
      bit  done;
      start = -1;
      done  = 0;
      if (m_busy != 0) begin
         if (i_ready) begin
            exp_q.push_back({CW'(m_chan), IW'(m_idx), m_pkt[m_chan][m_idx]});
            if (m_idx == PKT - 1) done = 1;
            else m_idx++;
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (start < 0 && m_full[(m_ptr + k) % NCH]) start = (m_ptr + k) % NCH;
         end
      end
      for (int c = 0; c < NCH; c++) begin
         if (i_flush) begin
            m_ovf[c] = 0;
            m_tout[c] = 0;
            if (!m_full[c]) begin
               m_cnt[c] = 0;
               m_sil[c] = 0;
            end
         end
         if (m_full[c]) begin
            if (i_valid[c]) m_ovf[c] = 1;
         end else if (i_valid[c]) begin
            m_part[c][m_cnt[c]] = i_data[c*DW +: DW];
            m_cnt[c]++;
            m_sil[c] = 0;
            if (m_cnt[c] == PKT) begin
               for (int b = 0; b < PKT; b++) m_pkt[c][b] = m_part[c][b];
               m_full[c] = 1;
               m_cnt[c] = 0;
            end
         end else if (m_cnt[c] > 0) begin
            m_sil[c]++;
            if (TOUT > 0 && m_sil[c] == TOUT) begin
               m_cnt[c] = 0;
               m_sil[c] = 0;
               m_tout[c] = 1;
            end
         end
      end
      if (done) begin
         m_full[m_chan] = 0;
         m_ptr = (m_chan + 1) % NCH;
         m_busy = 0;
         m_idx = 0;
      end
      if (start >= 0) begin
         m_busy = 1;
         m_chan = start;
         m_idx = 0;
      end
   endtask

   task automatic compare_outputs();
      logic [NCH-1:0] ef, eo, et;
      for (int c = 0; c < NCH; c++) begin
         ef[c] = m_full[c]; eo[c] = m_ovf[c]; et[c] = m_tout[c];
      end
      check("valid", 32'(o_valid), 32'(m_busy));
      check("busy", 32'(o_busy), 32'(m_busy));
      check("full", 32'(o_full), 32'(ef));
      check("ovf", 32'(o_ovf), 32'(eo));
      check("tout", 32'(o_tout), 32'(et));
      check("last", 32'(o_last), 32'(m_busy != 0 && m_idx == PKT - 1));
      if (m_busy != 0) begin
         check("chan", 32'(o_chan), 32'(m_chan));
         check("idx", 32'(o_idx), 32'(m_idx));
         check("data", 32'(o_data), 32'(m_pkt[m_chan][m_idx]));
      end
   endtask

   // driver tasks
   task automatic cycle();
      logic [W-1:0] got;
      logic [W-1:0] exp;
      bit           hs;
      hs  = o_valid && i_ready;
      got = {o_chan, o_idx, o_data};
      model_step();
      @(posedge clk);
      #1;
      if (hs) begin
         check("beat_expected", 32'(exp_q.size() > 0), 32'(1));
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("beat", 32'(got), 32'(exp));
         end
      end
      compare_outputs();
      @(negedge clk);
      i_valid = '0;
      i_flush = 1'b0;
      case (rdy_mode)
         0: i_ready = 1'b1;
         1: begin i_ready = (pat_cnt % 3 == 0); pat_cnt++; end
         2: i_ready = 1'($urandom_range(1));
         default: i_ready = 1'b0;
      endcase
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic feed(input logic [NCH-1:0] mask, input int n, input bit incr,
                       input logic [DW-1:0] base);
      for (int b = 0; b < n; b++) begin
         i_valid = mask;
         for (int c = 0; c < NCH; c++)
            i_data[c*DW +: DW] = incr ? base + DW'(b) : DW'($urandom);
         cycle();
      end
   endtask

   task automatic wait_busy(input int n);
      int k = 0;
      while (m_busy == 0 && k < n) begin
         cycle();
         k++;
      end
      if (m_busy == 0) check("wait_busy", 32'(o_busy), 32'(1));
   endtask

   initial begin
      int rates[4] = '{2, 6, 40, 90};
      int rate[NCH];
      rst = 1'b0; i_valid = '0; i_data = '0; i_flush = 1'b0; i_ready = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'(0));
      check("rst_busy", 32'(o_busy), 32'(0));
      check("rst_full", 32'(o_full), 32'(0));
      check("rst_ovf", 32'(o_ovf), 32'(0));
      check("rst_tout", 32'(o_tout), 32'(0));
      check("rst_data", 32'(o_data), 32'(0));
      check("rst_chan", 32'(o_chan), 32'(0));
      check("rst_idx", 32'(o_idx), 32'(0));
      check("rst_last", 32'(o_last), 32'(0));
      rst = 1'b1;
      idle(2);

      // channel 2 packet 0x10..0x1F, always ready
      feed(5'b00100, 16, 1'b1, 8'h10);
      idle(20);

      // ready pattern 1,0,0 on a channel-4 drain; leaves the pointer at 0
      rdy_mode = 1;
      feed(5'b10000, 16, 1'b0, 8'h00);
      idle(70);
      rdy_mode = 0; i_ready = 1'b1;

      // simultaneous completion on 0,3,4, then 0 and 1 complete while 4 drains
      feed(5'b11001, 16, 1'b0, 8'h00);
      idle(20);
      feed(5'b00011, 16, 1'b0, 8'h00);
      idle(80);

      // overflow into a full, stalled channel 1, then flush clears the flag
      rdy_mode = 3; i_ready = 1'b0;
      feed(5'b00010, 16, 1'b0, 8'h00);
      feed(5'b00010, 3, 1'b0, 8'h00);
      idle(3);
      rdy_mode = 0; i_ready = 1'b1;
      idle(25);
      i_flush = 1'b1;
      cycle();
      idle(2);

      // timeout on a 7-byte partial packet, then a clean packet
      feed(5'b01000, 7, 1'b0, 8'h00);
      idle(60);
      feed(5'b01000, 16, 1'b1, 8'hA0);
      idle(25);

      // flush mid-fill on channel 0 while channel 1 drains
      feed(5'b00010, 16, 1'b0, 8'h00);
      wait_busy(10);
      feed(5'b00001, 5, 1'b0, 8'h00);
      i_flush = 1'b1;
      feed(5'b00001, 1, 1'b0, 8'h00);
      feed(5'b00001, 15, 1'b1, 8'h40);
      idle(60);

      // asynchronous reset in the middle of a drain
      feed(5'b00100, 16, 1'b0, 8'h00);
      wait_busy(10);
      idle(4);
      #2 rst = 1'b0;
      #1;
      check("async_valid", 32'(o_valid), 32'(0));
      check("async_busy", 32'(o_busy), 32'(0));
      check("async_full", 32'(o_full), 32'(0));
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      idle(2);

      // randomised traffic: mixed byte rates, random ready, rare flushes
      rdy_mode = 2;
      for (int seg = 0; seg < 10; seg++) begin
         for (int c = 0; c < NCH; c++) rate[c] = rates[$urandom_range(3)];
         for (int t = 0; t < 200; t++) begin
            for (int c = 0; c < NCH; c++) begin
               i_valid[c] = ($urandom_range(rate[c] - 1) == 0);
               i_data[c*DW +: DW] = DW'($urandom);
            end
            i_flush = ($urandom_range(150) == 0);
            cycle();
         end
      end
      rdy_mode = 0; i_ready = 1'b1;
      idle(200);
      check("exp_q_drained", 32'(exp_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
